button_conditioner: RTL and testbench

//  Conditions the three raw push-button pins (MODE, UP, DOWN) into clean one-cycle pulses for the clock core.
//  - Each input is synchronised into clk and debounced.
//  - An edge detector produces a single pulse per press.
//  - UP/DOWN auto-repeat while held, for fast time setting.
//  - Sits directly upstream of the clock core: its outputs drive button_mode/button_up/button_down.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/key_debounce.sv | 63 ++++++
 rtl/button_conditioner.sv | 118 +++++++++++
 tb/tb_button_conditioner.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants and repeat-FSM state type for the clock front end
package clock_pkg;

    localparam int DEBOUNCE_50M      = 1_000_000;
    localparam int REPEAT_DELAY_50M  = 25_000_000;
    localparam int REPEAT_PERIOD_50M = 5_000_000;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        LOCK
    } rpt_state_t;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF sync, polarity normalise, debounce counter and press pulse
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50M,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic stable,
    output logic press
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           IDLE_LVL = ACTIVE_LOW;

    logic          meta_q, sync_q;
    logic          stable_q, stable_d;
    logic          stable_prev_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed;

    assign pressed = sync_q ^ ACTIVE_LOW;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (pressed == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = pressed;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        press_d = stable_q & ~stable_prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q        <= IDLE_LVL;
            sync_q        <= IDLE_LVL;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            meta_q        <= key_raw;
            sync_q        <= meta_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= press_d;
            cnt_q         <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - MODE/UP/DOWN conditioning with UP/DOWN auto-repeat and conflict lock
module button_conditioner
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50M,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_50M,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_50M,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_mode,
    input  logic key_up,
    input  logic key_down,
    output logic button_mode,
    output logic button_up,
    output logic button_down
);

    localparam int            TW         = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [TW-1:0] DELAY_MAX  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_MAX = TW'(REPEAT_PERIOD - 1);

    logic       mode_stable;
    logic       mode_press;
    logic [1:0] stable;
    logic [1:0] press;
    logic [1:0] rpt;
    logic [1:0] fire;
    logic       conflict;

    rpt_state_t    state_q [2];
    rpt_state_t    state_d [2];
    logic [TW-1:0] timer_q [2];
    logic [TW-1:0] timer_d [2];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_mode (
        .clk(clk), .rst_n(rst_n), .key_raw(key_mode), .stable(mode_stable), .press(mode_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_up (
        .clk(clk), .rst_n(rst_n), .key_raw(key_up), .stable(stable[0]), .press(press[0])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_down (
        .clk(clk), .rst_n(rst_n), .key_raw(key_down), .stable(stable[1]), .press(press[1])
    );

    assign conflict = stable[0] & stable[1];

    // Index 0 is UP, index 1 is DOWN; a held conflict parks both channels in LOCK.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            rpt[i]     = 1'b0;
            if (conflict) begin
                state_d[i] = LOCK;
                timer_d[i] = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (press[i]) begin
                            state_d[i] = DELAY;
                            timer_d[i] = '0;
                        end
                    end
                    DELAY: begin
                        if (!stable[i]) begin
                            state_d[i] = IDLE;
                        end else if (timer_q[i] == DELAY_MAX) begin
                            rpt[i]     = 1'b1;
                            state_d[i] = REPEAT;
                            timer_d[i] = '0;
                        end else begin
                            timer_d[i] = timer_q[i] + TW'(1);
                        end
                    end
                    REPEAT: begin
                        if (!stable[i]) begin
                            state_d[i] = IDLE;
                        end else if (timer_q[i] == PERIOD_MAX) begin
                            rpt[i]     = 1'b1;
                            timer_d[i] = '0;
                        end else begin
                            timer_d[i] = timer_q[i] + TW'(1);
                        end
                    end
                    default: begin
                        if (!stable[i]) begin
                            state_d[i] = IDLE;
                        end
                    end
                endcase
            end
            fire[i] = ~conflict & (rpt[i] | (press[i] & (state_q[i] == IDLE)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign button_mode = mode_press;
    assign button_up   = fire[0];
    assign button_down = fire[1];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic key_mode, key_up, key_down;
    logic button_mode, button_up, button_down;

    int cyc = 0;
    int up_q[$];
    int down_q[$];
    int mode_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(5),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_mode(key_mode),
        .key_up(key_up),
        .key_down(key_down),
        .button_mode(button_mode),
        .button_up(button_up),
        .button_down(button_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (button_up)   up_q.push_back(cyc);
        if (button_down) down_q.push_back(cyc);
        if (button_mode) mode_q.push_back(cyc);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int at_q(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    task automatic wait_up(input int base, input int limit);
        for (int i = 0; i < limit && up_q.size() == base; i++) tick(1);
    endtask

    task automatic tick_until(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) tick(1);
    endtask

    int bu, bd, bm, t0, tl, tr, tm;
    bit k;

    initial begin
        rst_n = 1'b0; key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
        tick(3);
        check("rst_mode", int'(button_mode), 0);
        check("rst_up",   int'(button_up),   0);
        check("rst_down", int'(button_down), 0);
        rst_n = 1'b1;
        tick(50);
        check("idle_up",   up_q.size(),   0);
        check("idle_down", down_q.size(), 0);
        check("idle_mode", mode_q.size(), 0);

        // Bounce for 12 cycles, then settle low
        bu = up_q.size();
        k = 1'b1;
        for (int i = 0; i < 6; i++) begin
            k = ~k;
            key_up = k;
            tick(2);
        end
        key_up = 1'b0;
        tl = cyc;
        wait_up(bu, 30);
        check("bounce_cnt", up_q.size() - bu, 1);
        t0 = at_q(up_q, bu);
        check("bounce_lat", t0 - tl, 7);

        // Keep holding for repeats, release after the t0+30 pulse
        tick_until(t0 + 33);
        key_up = 1'b1;
        tick(50);
        check("rpt_first",  at_q(up_q, bu + 1) - t0, 20);
        check("rpt_second", at_q(up_q, bu + 2) - t0, 25);
        check("rpt_third",  at_q(up_q, bu + 3) - t0, 30);
        check("rpt_inflt",  at_q(up_q, bu + 4) - t0, 35);
        check("rpt_total",  up_q.size() - bu, 5);

        // Conflict with a MODE tap inside it
        bu = up_q.size(); bd = down_q.size(); bm = mode_q.size();
        key_up = 1'b0; key_down = 1'b0;
        tick(20);
        key_mode = 1'b0;
        tm = cyc;
        tick(10);
        key_mode = 1'b1;
        tick(30);
        check("cfl_up",   up_q.size() - bu,   0);
        check("cfl_down", down_q.size() - bd, 0);
        check("cfl_mode", mode_q.size() - bm, 1);
        check("cfl_mlat", at_q(mode_q, bm) - tm, 7);
        key_down = 1'b1;
        tick(40);
        check("lock_surv", up_q.size() - bu, 0);
        key_up = 1'b1;
        tick(20);

        // Mid-operation reset while repeating
        bu = up_q.size();
        key_up = 1'b0;
        wait_up(bu, 30);
        t0 = at_q(up_q, bu);
        tick_until(t0 + 25);
        check("mid_live", int'(button_up), 1);
        rst_n = 1'b0;
        #1;
        check("mid_async", int'(button_up), 0);
        tick(3);
        check("mid_hold", int'(button_up), 0);
        rst_n = 1'b1;
        tr = cyc;
        bu = up_q.size();
        tick(30);
        check("mid_press", at_q(up_q, bu) - tr, 7);
        check("mid_delay", at_q(up_q, bu + 1) - tr, 27);
        key_up = 1'b1;
        tick(20);

        // MODE held long never repeats
        bm = mode_q.size();
        key_mode = 1'b0;
        tm = cyc;
        tick(200);
        check("mhold_cnt", mode_q.size() - bm, 1);
        check("mhold_lat", at_q(mode_q, bm) - tm, 7);
        key_mode = 1'b1;
        tick(20);
        check("mrel_cnt", mode_q.size() - bm, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
